// File: rtl/pulse_mon_pkg.sv
// Shared types for the divider strobe monitor: FSM state encoding and good-counter sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pulse_mon_pkg;

    typedef enum logic [1:0] {
        MON_IDLE   = 2'd0,
        MON_SYNC   = 2'd1,
        MON_ACQ    = 2'd2,
        MON_LOCKED = 2'd3
    } mon_state_t;

    // The good counter has to hold the value LOCK_COUNT itself.
    function automatic int good_width(input int lock_count);
        return (lock_count < 1) ? 1 : $clog2(lock_count + 1);
    endfunction

endpackage

// File: rtl/sat_gap_counter.sv
// Saturating cycle counter measuring the distance since the last strobe.
// Latency: registered; g reflects en/clear_to_one one cycle later.
// Backpressure: none; free-running while enabled.
//
// Ports: clk, reset (async, active-high), en (0 clears g to 0),
//        clear_to_one (strobe seen: restart at 1), g (count, holds at all-ones).
module sat_gap_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear_to_one,
    output logic [CNT_W-1:0] g
);

    localparam logic [CNT_W-1:0] G_MAX = '1;
    localparam logic [CNT_W-1:0] G_ONE = CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g <= '0;
        end else if (!en) begin
            g <= '0;
        end else if (clear_to_one) begin
            // The strobe cycle itself is gap 0, so the next cycle is 1.
            g <= G_ONE;
        end else if (g != G_MAX) begin
            g <= g + G_ONE;
        end
    end

endmodule

// File: rtl/divider_pulse_monitor.sv
// Checks a divider's one-hot strobe: measures spacing, locks after LOCK_COUNT good periods, flags errors.
// Latency: all outputs registered; locked/err_pulse/err_count/period change 1 cycle after the causing event.
// Backpressure: none; pulse_in is sampled every cycle.
//
// Ports: clk, reset (async, active-high), en (0 forces MON_IDLE), pulse_in (strobe),
//        locked, err_pulse (1-cycle), err_count (saturating), period (last gap), state.
// Build option PULSE_MON_IRQ_EN: adds input irq_clr and sticky output irq (set beats clear).
module divider_pulse_monitor
    import pulse_mon_pkg::*;
#(
    parameter int DIV        = 3,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pulse_in,
`ifdef PULSE_MON_IRQ_EN
    input  logic             irq_clr,
`endif
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] period,
`ifdef PULSE_MON_IRQ_EN
    output logic             irq,
`endif
    output logic [1:0]       state
);

    localparam int                GOOD_W  = good_width(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  DIV_C   = CNT_W'(DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
    localparam logic [GOOD_W-1:0] LOCK_C  = GOOD_W'(LOCK_COUNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);

    mon_state_t        st_q, st_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic [CNT_W-1:0]  period_d;
    logic [CNT_W-1:0]  g;
    logic              err_d;
    logic              gap_en;

    // Holding the counter disabled in IDLE makes entry to SYNC start from g=0.
    assign gap_en = en && (st_q != MON_IDLE);

    sat_gap_counter #(.CNT_W(CNT_W)) u_gap (
        .clk          (clk),
        .reset        (reset),
        .en           (gap_en),
        .clear_to_one (pulse_in),
        .g            (g)
    );

    always_comb begin
        st_d     = st_q;
        good_d   = good_q;
        period_d = period;
        err_d    = 1'b0;
        if (!en) begin
            st_d   = MON_IDLE;
            good_d = '0;
        end else begin
            case (st_q)
                MON_IDLE: begin
                    st_d   = MON_SYNC;
                    good_d = '0;
                end
                MON_SYNC: begin
                    // First strobe only establishes the reference; no period yet.
                    good_d = '0;
                    if (pulse_in) st_d = MON_ACQ;
                end
                MON_ACQ: begin
                    if (pulse_in) begin
                        period_d = g;
                        if (g == DIV_C) begin
                            good_d = good_q + GOOD_ONE;
                            if (good_q + GOOD_ONE == LOCK_C) st_d = MON_LOCKED;
                        end else begin
                            good_d = '0;
                        end
                    end else if (g == DIV_C) begin
                        // Expected strobe missing while acquiring: quietly resync.
                        st_d   = MON_SYNC;
                        good_d = '0;
                    end
                end
                MON_LOCKED: begin
                    if (pulse_in) begin
                        period_d = g;
                        if (g != DIV_C) begin
                            // Early or stretched strobe; it becomes the new reference.
                            err_d  = 1'b1;
                            st_d   = MON_ACQ;
                            good_d = '0;
                        end
                    end else if (g == DIV_C) begin
                        err_d  = 1'b1;
                        st_d   = MON_SYNC;
                        good_d = '0;
                    end
                end
                default: begin
                    st_d   = MON_IDLE;
                    good_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q      <= MON_IDLE;
            good_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            period    <= '0;
        end else begin
            st_q      <= st_d;
            good_q    <= good_d;
            locked    <= (st_d == MON_LOCKED);
            err_pulse <= err_d;
            period    <= period_d;
            if (err_d && (err_count != CNT_MAX)) err_count <= err_count + CNT_ONE;
        end
    end

`ifdef PULSE_MON_IRQ_EN
    // Keyed off the same condition as err_pulse so irq rises with it; a set beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else if (err_d) begin
            irq <= 1'b1;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end
`endif

    assign state = st_q;

endmodule

// File: tb/tb_divider_pulse_monitor.sv
// Self-checking bench for divider_pulse_monitor (DIV=3, LOCK_COUNT=4, CNT_W=4).
// Every cycle the DUT outputs are compared against a timestamp-based reference model.
// Directed scenarios cover locking, early/missing/stretched strobes, saturation and async reset.
module tb_divider_pulse_monitor;
    import pulse_mon_pkg::*;

    localparam int DIV  = 3;
    localparam int LC   = 4;
    localparam int CW   = 4;
    localparam int GMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          pulse_in;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic [CW-1:0] period;
    logic [1:0]    state;

    always #5 clk = ~clk;

    divider_pulse_monitor #(.DIV(DIV), .LOCK_COUNT(LC), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pulse_in  (pulse_in),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .period    (period),
        .state     (state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    // Reference model: the gap is "cycles since the reference timestamp", capped at GMAX.
    mon_state_t m_state;
    int         m_cyc;     // index of the current cycle
    int         m_ref;     // cycle at which the gap was 0
    int         m_run;     // consecutive on-time periods while acquiring
    int         m_period;
    int         m_errs;
    bit         m_err;
    bit         m_locked;

    function automatic int m_gap();
        int d;
        d = m_cyc - m_ref;
        return (d > GMAX) ? GMAX : d;
    endfunction

    task automatic model_reset();
        m_state  = MON_IDLE;
        m_ref    = m_cyc;
        m_run    = 0;
        m_period = 0;
        m_errs   = 0;
        m_err    = 0;
        m_locked = 0;
    endtask

    task automatic model_edge(input bit p, input bit e);
        int         gap;
        int         nref;
        mon_state_t nst;
        gap   = m_gap();
        nst   = m_state;
        m_err = 0;
        if (!e || m_state == MON_IDLE) nref = m_cyc + 1;
        else if (p)                    nref = m_cyc;
        else                           nref = m_ref;
        if (!e) begin
            nst   = MON_IDLE;
            m_run = 0;
        end else if (m_state == MON_IDLE) begin
            nst   = MON_SYNC;
            m_run = 0;
        end else if (m_state == MON_SYNC) begin
            m_run = 0;
            if (p) nst = MON_ACQ;
        end else if (p) begin
            m_period = gap;
            if (gap == DIV) begin
                if (m_state == MON_ACQ) begin
                    m_run++;
                    if (m_run == LC) nst = MON_LOCKED;
                end
            end else begin
                m_run = 0;
                if (m_state == MON_LOCKED) begin
                    m_err = 1;
                    nst   = MON_ACQ;
                end
            end
        end else if (gap == DIV) begin
            m_run = 0;
            m_err = (m_state == MON_LOCKED);
            nst   = MON_SYNC;
        end
        if (m_err && m_errs < GMAX) m_errs++;
        m_state  = nst;
        m_locked = (nst == MON_LOCKED);
        m_ref    = nref;
        m_cyc++;
    endtask

    task automatic compare_all();
        check("state",     state,     m_state);
        check("locked",    locked,    m_locked);
        check("err_pulse", err_pulse, m_err);
        check("err_count", err_count, m_errs);
        check("period",    period,    m_period);
    endtask

    // One clock: drive at negedge, model at posedge, compare at the next negedge.
    task automatic step(input bit p, input bit e);
        pulse_in = p;
        en       = e;
        @(posedge clk);
        model_edge(p, e);
        @(negedge clk);
        compare_all();
    endtask

    // n strobes, each gap cycles after the previous one (gap=1 means back-to-back).
    task automatic pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap - 1) step(0, 1);
            step(1, 1);
        end
    endtask

    task automatic acquire_lock();
        step(0, 0);
        step(0, 1);
        step(1, 1);
        pulses(LC, DIV);
    endtask

    initial begin
        reset    = 1'b1;
        en       = 1'b0;
        pulse_in = 1'b0;
        m_cyc    = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_state",  state,     MON_IDLE);
        check("rst_locked", locked,    0);
        check("rst_err",    err_pulse, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_period", period,    0);
        reset = 1'b0;

        // Lock on a clean train: reference strobe plus LC on-time periods.
        step(0, 1);
        step(0, 1);
        step(1, 1);
        pulses(LC - 1, DIV);
        check("t1_not_yet", locked, 0);
        pulses(1, DIV);
        check("t1_locked", locked, 1);
        check("t1_period", period, DIV);
        check("t1_errcnt", err_count, 0);

        // Early strobe while locked.
        pulses(1, DIV - 1);
        check("t2_err",    err_pulse, 1);
        check("t2_errcnt", err_count, 1);
        check("t2_period", period, DIV - 1);
        check("t2_state",  state, MON_ACQ);
        pulses(LC, DIV);
        check("t2_relock", locked, 1);

        // Missing strobe while locked.
        step(0, 1);
        step(0, 1);
        check("t3_pre", err_pulse, 0);
        step(0, 1);
        check("t3_err",    err_pulse, 1);
        check("t3_state",  state, MON_SYNC);
        check("t3_locked", locked, 0);
        step(1, 1);
        pulses(LC, DIV);

        // Strobe held high for two cycles.
        step(1, 1);
        check("t4_period", period, 1);
        check("t4_err",    err_pulse, 1);
        check("t4_errcnt", err_count, 3);

        // Drive the error count past saturation.
        for (int i = 0; i < 17; i++) begin
            pulses(LC, DIV);
            pulses(1, DIV - 1);
        end
        check("t5_errsat", err_count, GMAX);
        repeat (40) step(0, 1);
        check("t5_gapsat", dut.u_gap.g, GMAX);
        check("t5_state",  state, MON_SYNC);

        // Randomized traffic: mostly on-time strobes with occasional faults and enable drops.
        acquire_lock();
        reset = 1'b1;          // wipe the error count so the random phase starts unsaturated
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        acquire_lock();
        for (int k = 0; k < 600; k++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)       repeat ($urandom_range(1, 3)) step(0, 0);
            else if (r < 75) pulses(1, DIV);
            else if (r < 88) pulses(1, $urandom_range(1, DIV + 2));
            else             repeat ($urandom_range(1, 6)) step(0, 1);
        end

        // Asynchronous reset while locked.
        acquire_lock();
        check("t6_locked", locked, 1);
        #2 reset = 1'b1;
        #1;
        check("t6_state",  state,     MON_IDLE);
        check("t6_locked", locked,    0);
        check("t6_err",    err_pulse, 0);
        check("t6_errcnt", err_count, 0);
        check("t6_period", period,    0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        acquire_lock();
        check("t6_relock", locked, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
